// File: rtl/decoder_pkg.sv
// Shared types and constants for the RV32 decode stage: format enum,
// major opcodes, register-field positions and small classification helpers.
package decoder_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_A   = 3'd6,
        FMT_ILL = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_W   = 5;

    // Any opcode outside the table (including inst[1:0] != 2'b11) is ILL.
    function automatic fmt_t fmt_of(input logic [6:0] opc);
        fmt_t f;
        case (opc)
            OP_OP:                                 f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   f = FMT_I;
            OP_STORE:                              f = FMT_S;
            OP_BRANCH:                             f = FMT_B;
            OP_LUI, OP_AUIPC:                      f = FMT_U;
            OP_JAL:                                f = FMT_J;
            OP_AMO:                                f = FMT_A;
            default:                               f = FMT_ILL;
        endcase
        return f;
    endfunction

    // Which register fields a format reads/writes, as {rd, rs1, rs2}.
    function automatic logic [2:0] use_of(input fmt_t f);
        logic [2:0] m;
        case (f)
            FMT_R, FMT_A: m = 3'b111;
            FMT_I:        m = 3'b110;
            FMT_S, FMT_B: m = 3'b011;
            FMT_U, FMT_J: m = 3'b100;
            default:      m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational decode of a single RV32 instruction: format, raw register
// fields, use flags (zero-index registers are never flagged), immediate
// and illegal indication.
module decode_lane
    import decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output fmt_t            fmt_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic            rd_use_o,
    output logic            rs1_use_o,
    output logic            rs2_use_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [2:0]         use_mask;
    logic signed [31:0] imm32;

    // Classify the opcode, slice the fields and assemble the immediate
    always_comb begin
        fmt_o     = fmt_of(inst_i[OPC_LSB +: OPC_W]);
        rd_o      = inst_i[RD_LSB  +: REG_W];
        rs1_o     = inst_i[RS1_LSB +: REG_W];
        rs2_o     = inst_i[RS2_LSB +: REG_W];
        use_mask  = use_of(fmt_o);
        rd_use_o  = use_mask[2] & (rd_o  != 5'd0);
        rs1_use_o = use_mask[1] & (rs1_o != 5'd0);
        rs2_use_o = use_mask[0] & (rs2_o != 5'd0);
        illegal_o = (fmt_o == FMT_ILL);
        case (fmt_o)
            FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U:   imm32 = {inst_i[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Signed source, so widening to XLEN sign-extends
        imm_o = XLEN'(imm32);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane RV32 decode stage with a main + skid register pair,
// so in_ready_o is a pure register output. Optional performance counters
// are compiled in when DECODE_PERF_EN is defined.
module decode_stage
    import decoder_pkg::*;
#(
    parameter int LANES = 1,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [32*LANES-1:0]   in_inst_i,
    input  logic [LANES-1:0]      in_lane_vld_i,
    input  logic [XLEN-1:0]       in_pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES-1:0]      out_lane_vld_o,
    output logic [XLEN*LANES-1:0] out_pc_o,
    output logic [3*LANES-1:0]    out_fmt_o,
    output logic [5*LANES-1:0]    out_rd_o,
    output logic [5*LANES-1:0]    out_rs1_o,
    output logic [5*LANES-1:0]    out_rs2_o,
    output logic [LANES-1:0]      out_rd_use_o,
    output logic [LANES-1:0]      out_rs1_use_o,
    output logic [LANES-1:0]      out_rs2_use_o,
    output logic [XLEN*LANES-1:0] out_imm_o,
    output logic [LANES-1:0]      out_illegal_o
`ifdef DECODE_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_decoded_o,
    output logic [CNT_W-1:0]      perf_illegal_o
`endif
);

    // Per-lane payload: {pc, fmt, rd, rs1, rs2, rd_use, rs1_use, rs2_use, imm, illegal}
    localparam int PW = 2*XLEN + 22;

    logic [LANES-1:0][PW-1:0] dec_payload;
    logic [LANES-1:0][PW-1:0] main_q, main_d, skid_q, skid_d;
    logic [LANES-1:0]         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic                     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic                     accept, load, deliver;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            fmt_t            fmt;
            logic [4:0]      rd, rs1, rs2;
            logic            rd_use, rs1_use, rs2_use, illegal;
            logic [XLEN-1:0] imm, pc;

            decode_lane #(.XLEN(XLEN)) u_lane (
                .inst_i    (in_inst_i[32*gi +: 32]),
                .fmt_o     (fmt),
                .rd_o      (rd),
                .rs1_o     (rs1),
                .rs2_o     (rs2),
                .rd_use_o  (rd_use),
                .rs1_use_o (rs1_use),
                .rs2_use_o (rs2_use),
                .imm_o     (imm),
                .illegal_o (illegal)
            );

            // Lane pc wraps naturally at 2^XLEN
            assign pc = in_pc_i + XLEN'(4*gi);
            assign dec_payload[gi] = {pc, fmt, rd, rs1, rs2,
                                      rd_use, rs1_use, rs2_use, imm, illegal};

            assign {out_pc_o[XLEN*gi +: XLEN], out_fmt_o[3*gi +: 3],
                    out_rd_o[5*gi +: 5], out_rs1_o[5*gi +: 5], out_rs2_o[5*gi +: 5],
                    out_rd_use_o[gi], out_rs1_use_o[gi], out_rs2_use_o[gi],
                    out_imm_o[XLEN*gi +: XLEN], out_illegal_o[gi]} = main_q[gi];
        end
    endgenerate

    assign in_ready_o     = !skid_valid_q;
    assign out_valid_o    = main_valid_q;
    assign out_lane_vld_o = main_vld_q;
    assign accept         = in_valid_i & in_ready_o;
    // A bundle with no valid lanes is handshaken but never stored
    assign load           = accept & (|in_lane_vld_i);
    assign deliver        = main_valid_q & out_ready_i;

    // Next state of the main/skid pair: skid refills main first, keeping FIFO order
    always_comb begin
        main_d       = main_q;
        main_vld_d   = main_vld_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_vld_d   = skid_vld_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || deliver) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_vld_d   = skid_vld_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = load;
                if (load) begin
                    main_d     = dec_payload;
                    main_vld_d = in_lane_vld_i;
                end
            end
        end else if (load) begin
            skid_d       = dec_payload;
            skid_vld_d   = in_lane_vld_i;
            skid_valid_d = 1'b1;
        end
    end

    // Main and skid registers with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q       <= '0;
            main_vld_q   <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_vld_q   <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_vld_q   <= main_vld_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_vld_q   <= skid_vld_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] perf_decoded_q, perf_illegal_q;

    // Count delivered valid lanes and the illegal ones among them; flush does not clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else if (deliver) begin
            perf_decoded_q <= perf_decoded_q + CNT_W'($countones(out_lane_vld_o));
            perf_illegal_q <= perf_illegal_q + CNT_W'($countones(out_lane_vld_o & out_illegal_o));
        end
    end

    assign perf_decoded_o = perf_decoded_q;
    assign perf_illegal_o = perf_illegal_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (LANES=2): table-driven decode vectors,
// then hand-written stall, flush, reset and (with DECODE_PERF_EN) counter sequences.
module tb_decode_stage;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam int NI    = 11;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_inst;
    logic [1:0]  in_lane_vld, out_lane_vld;
    logic [31:0] in_pc;
    logic [63:0] out_pc, out_imm;
    logic [5:0]  out_fmt;
    logic [9:0]  out_rd, out_rs1, out_rs2;
    logic [1:0]  out_rd_use, out_rs1_use, out_rs2_use, out_illegal;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_decoded, perf_illegal;
`endif

    decode_stage #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_inst_i      (in_inst),
        .in_lane_vld_i  (in_lane_vld),
        .in_pc_i        (in_pc),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_lane_vld_o (out_lane_vld),
        .out_pc_o       (out_pc),
        .out_fmt_o      (out_fmt),
        .out_rd_o       (out_rd),
        .out_rs1_o      (out_rs1),
        .out_rs2_o      (out_rs2),
        .out_rd_use_o   (out_rd_use),
        .out_rs1_use_o  (out_rs1_use),
        .out_rs2_use_o  (out_rs2_use),
        .out_imm_o      (out_imm),
        .out_illegal_o  (out_illegal)
`ifdef DECODE_PERF_EN
        ,
        .perf_decoded_o (perf_decoded),
        .perf_illegal_o (perf_illegal)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  uses;   // {rd, rs1, rs2}
        logic [31:0] imm;
        logic        ill;
    } ivec_t;

    typedef struct {
        int          l0;
        int          l1;
        logic [31:0] pc;
        logic [31:0] pc1;
    } bvec_t;

    ivec_t       itab[NI];
    bvec_t       btab[NI];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] got_q[$];
    logic        mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record lane-0 pc of every bundle that will be delivered on the next edge
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) got_q.push_back(out_pc[31:0]);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [1:0] lv);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_inst     = {i1, i0};
        in_lane_vld = lv;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_lane_vld = '0; in_pc = '0;

        //            inst          fmt   rd     rs1    rs2    use     imm            ill
        itab[0]  = '{32'hFFF00093, 3'd1, 5'd1,  5'd0,  5'd31, 3'b100, 32'hFFFFFFFF, 1'b0};
        itab[1]  = '{32'hFE000EE3, 3'd3, 5'd29, 5'd0,  5'd0,  3'b000, 32'hFFFFFFFC, 1'b0};
        itab[2]  = '{32'h00000000, 3'd7, 5'd0,  5'd0,  5'd0,  3'b000, 32'h00000000, 1'b1};
        itab[3]  = '{32'h002081B3, 3'd0, 5'd3,  5'd1,  5'd2,  3'b111, 32'h00000000, 1'b0};
        itab[4]  = '{32'hFE532C23, 3'd2, 5'd24, 5'd6,  5'd5,  3'b011, 32'hFFFFFFF8, 1'b0};
        itab[5]  = '{32'h12345537, 3'd4, 5'd10, 5'd8,  5'd3,  3'b100, 32'h12345000, 1'b0};
        itab[6]  = '{32'h008000EF, 3'd5, 5'd1,  5'd0,  5'd8,  3'b100, 32'h00000008, 1'b0};
        itab[7]  = '{32'h0053222F, 3'd6, 5'd4,  5'd6,  5'd5,  3'b111, 32'h00000000, 1'b0};
        itab[8]  = '{32'h00000090, 3'd7, 5'd1,  5'd0,  5'd0,  3'b000, 32'h00000000, 1'b1};
        itab[9]  = '{32'h00412383, 3'd1, 5'd7,  5'd2,  5'd4,  3'b110, 32'h00000004, 1'b0};
        itab[10] = '{32'hFFFFF017, 3'd4, 5'd0,  5'd31, 5'd31, 3'b000, 32'hFFFFF000, 1'b0};

        for (int k = 0; k < NI; k++) begin
            btab[k] = '{k, (k + 1) % NI, 32'h1000 + 32'(k) * 32'h10, 32'h1004 + 32'(k) * 32'h10};
        end
        btab[NI-1].pc  = 32'hFFFFFFFC;   // lane 1 pc must wrap
        btab[NI-1].pc1 = 32'h00000000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_imm", out_imm, 64'h0);
        chk("rst.out_pc", out_pc, 64'h0);
        chk("rst.lane_vld", out_lane_vld, 2'b00);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Table-driven decode vectors, one bundle at a time, latency one cycle
        for (int k = 0; k < NI; k++) begin
            drive(btab[k].pc, itab[btab[k].l0].inst, itab[btab[k].l1].inst, 2'b11);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d.out_valid", k), out_valid, 1'b1);
            chk($sformatf("v%0d.lane_vld", k), out_lane_vld, 2'b11);
            chk($sformatf("v%0d.pc0", k), out_pc[31:0], btab[k].pc);
            chk($sformatf("v%0d.pc1", k), out_pc[63:32], btab[k].pc1);
            for (int l = 0; l < LANES; l++) begin
                int ix;
                ix = (l == 0) ? btab[k].l0 : btab[k].l1;
                chk($sformatf("v%0d.l%0d.fmt", k, l), out_fmt[3*l +: 3], itab[ix].fmt);
                chk($sformatf("v%0d.l%0d.rd", k, l), out_rd[5*l +: 5], itab[ix].rd);
                chk($sformatf("v%0d.l%0d.rs1", k, l), out_rs1[5*l +: 5], itab[ix].rs1);
                chk($sformatf("v%0d.l%0d.rs2", k, l), out_rs2[5*l +: 5], itab[ix].rs2);
                chk($sformatf("v%0d.l%0d.use", k, l),
                    {out_rd_use[l], out_rs1_use[l], out_rs2_use[l]}, itab[ix].uses);
                chk($sformatf("v%0d.l%0d.imm", k, l), out_imm[32*l +: 32], itab[ix].imm);
                chk($sformatf("v%0d.l%0d.ill", k, l), out_illegal[l], itab[ix].ill);
            end
            tick();
        end
        chk("tab.drained", out_valid, 1'b0);

        // Empty bundle is accepted and discarded
        drive(32'h2000, 32'h002081B3, 32'h002081B3, 2'b00);
        tick();
        in_valid = 1'b0;
        chk("empty.out_valid", out_valid, 1'b0);
        chk("empty.in_ready", in_ready, 1'b1);

        // Partial bundle keeps its lane mask
        drive(32'h2100, 32'h002081B3, 32'h00000000, 2'b01);
        tick();
        in_valid = 1'b0;
        chk("part.out_valid", out_valid, 1'b1);
        chk("part.lane_vld", out_lane_vld, 2'b01);
        tick();

        // Stall: A to main, B to skid, C held upstream; release delivers A,B,C once each
        out_ready = 1'b0;
        got_q.delete();
        mon_en = 1'b1;
        drive(32'h100, 32'h00412383, 32'h00412383, 2'b11);
        tick();
        chk("stall.ready_after_A", in_ready, 1'b1);
        drive(32'h200, 32'h00412383, 32'h00412383, 2'b11);
        tick();
        chk("stall.ready_after_B", in_ready, 1'b0);
        chk("stall.main_is_A", out_pc[31:0], 32'h100);
        drive(32'h300, 32'h00412383, 32'h00412383, 2'b11);
        repeat (3) tick();
        chk("stall.C_held", in_ready, 1'b0);
        chk("stall.main_still_A", out_pc[31:0], 32'h100);
        out_ready = 1'b1;
        tick();
        chk("stall.main_is_B", out_pc[31:0], 32'h200);
        chk("stall.ready_again", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("stall.main_is_C", out_pc[31:0], 32'h300);
        tick();
        chk("stall.drained", out_valid, 1'b0);
        mon_en = 1'b0;
        chk("stall.count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("stall.order0", got_q[0], 32'h100);
            chk("stall.order1", got_q[1], 32'h200);
            chk("stall.order2", got_q[2], 32'h300);
        end

        // Flush with main full: bundle presented in the flush cycle is dropped
        out_ready = 1'b0;
        drive(32'h400, 32'h002081B3, 32'h002081B3, 2'b11);
        tick();
        chk("flush1.pre_valid", out_valid, 1'b1);
        flush = 1'b1;
        drive(32'h500, 32'h002081B3, 32'h002081B3, 2'b11);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1.out_valid", out_valid, 1'b0);
        chk("flush1.in_ready", in_ready, 1'b1);
        tick();
        chk("flush1.dropped", out_valid, 1'b0);

        // Flush with main and skid full plus an incoming bundle
        drive(32'h600, 32'h002081B3, 32'h002081B3, 2'b11);
        tick();
        drive(32'h700, 32'h002081B3, 32'h002081B3, 2'b11);
        tick();
        chk("flush2.pre_ready", in_ready, 1'b0);
        flush = 1'b1;
        drive(32'h800, 32'h002081B3, 32'h002081B3, 2'b11);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush2.out_valid", out_valid, 1'b0);
        chk("flush2.in_ready", in_ready, 1'b1);
        tick();
        chk("flush2.stays_empty", out_valid, 1'b0);

        // Reset mid-stream with both entries full clears immediately
        drive(32'h900, 32'hFFF00093, 32'hFFF00093, 2'b11);
        tick();
        drive(32'hA00, 32'hFFF00093, 32'hFFF00093, 2'b11);
        tick();
        in_valid = 1'b0;
        chk("arst.pre_valid", out_valid, 1'b1);
        chk("arst.pre_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.out_valid", out_valid, 1'b0);
        chk("arst.in_ready", in_ready, 1'b1);
        chk("arst.out_imm", out_imm, 64'h0);
`ifdef DECODE_PERF_EN
        chk("arst.perf_dec", perf_decoded, 32'd0);
        chk("arst.perf_ill", perf_illegal, 32'd0);
`endif
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

`ifdef DECODE_PERF_EN
        // Counters: one illegal of two lanes, then invalid lane not counted, then flush+deliver
        drive(32'hB00, 32'h00000000, 32'h002081B3, 2'b11);
        tick();
        in_valid = 1'b0;
        tick();
        chk("perf.dec1", perf_decoded, 32'd2);
        chk("perf.ill1", perf_illegal, 32'd1);
        drive(32'hC00, 32'h00000000, 32'h00000000, 2'b01);
        tick();
        in_valid = 1'b0;
        tick();
        chk("perf.dec2", perf_decoded, 32'd3);
        chk("perf.ill2", perf_illegal, 32'd2);
        drive(32'hD00, 32'h00000000, 32'h00000000, 2'b11);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf.flush_valid", out_valid, 1'b0);
        chk("perf.dec3", perf_decoded, 32'd5);
        chk("perf.ill3", perf_illegal, 32'd4);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
